fpu_add_exp_compare: RTL
========================

// Module: fpu_add_exp_compare
// PURPOSE
//   Upstream stage of the FP32 add/sub datapath, in front of the alignment right-shifter.
//   Unpacks two IEEE-754 single operands and orders them by magnitude (big/small swap).
//   Computes the clamped alignment shift amount, the effective operation and special-case flags.
//   Two-stage pipeline with valid/ready handshake; its outputs drive the shifter's sig_small_in/shift_amt.
// PARAMETERS
//   EXP_W      8    exponent width
//   SIG_W      24   significand width incl. hidden bit
//   SHIFT_CAP  27   max shift; any larger exponent difference saturates to this
// PORTS
//   clk        in   1      clock; all state on rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      stage can accept operands this cycle
//   op_a       in   32     IEEE-754 single operand A
//   op_b       in   32     IEEE-754 single operand B
//   op_sub     in   1      1 = A - B, 0 = A + B
//   out_valid  out  1      result fields valid
//   out_ready  in   1      downstream accepts this cycle
//   sig_big    out  SIG_W  significand of larger-magnitude operand
//   sig_small  out  SIG_W  significand of smaller-magnitude operand (to shifter)
//   shift_amt  out  5      min(exp_big - exp_small, SHIFT_CAP)
//   exp_big    out  EXP_W  effective exponent of larger operand
//   sign_res   out  1      sign of larger operand (B's sign flipped when op_sub)
//   eff_sub    out  1      sign_a XOR sign_b XOR op_sub
//   is_nan     out  1      result is NaN (NaN input or inf - inf)
//   is_inf     out  1      result is infinity (not NaN)
//   is_zero    out  1      both operands are +/-0
// BEHAVIOUR
//   Reset: every output 0 (incl. out_valid); in_ready 1 in the cycle after rst deasserts.
//   Reset mid-operation: both stages flushed, in-flight data dropped, no out_valid pulse.
//   Handshake: transfer when valid&ready; out_* fields hold stable while out_valid & !out_ready.
//   Stage S1 (register on input accept):
//     - unpack: exp==0 -> eff exp 1, hidden bit 0; else hidden bit 1
//     - eff sign of B = sign_b ^ op_sub
//     - classify zero/inf/nan per operand
//   Stage S2 (register on S1->S2 advance):
//     - compare {eff_exp, sig} unsigned; A >= B -> A is big (tie keeps A big)
//     - diff = exp_big - exp_small (EXP_W bits, never negative); shift_amt = diff > 27 ? 27 : diff
//   Latency: 2 cycles from accepted input to out_valid with no back-pressure; throughput 1/cycle.
//   Flow control: S2 advances if !s2_valid | out_ready.
//     S1 advances if !s1_valid | S2 advances; in_ready = that S1 condition (combinational).
//   Full pipeline + out_ready low: in_ready 0, no data lost or duplicated.
//   Simultaneous accept and output in the same cycle: allowed, no bubble inserted.
//   Specials:
//     - any NaN, or inf with eff_sub and both inf -> is_nan=1, is_inf=0
//     - one inf -> is_inf=1, sign_res = inf sign
//     - +0 + -0: is_zero=1, sign_res = sign_a & eff sign_b
//     - data fields still computed as normal on specials
// TESTING
//   0x3F800000 + 0x40000000 -> 2 cycles: swap, sig_big=0x800000, sig_small=0x800000, shift_amt=1, exp_big=0x80, eff_sub=0.
//   0x3F800000 + 0x2B800000 (diff 40) -> shift_amt=27 (saturated), exp_big=0x7F, sig_small=0x800000.
//   0x00000001 + 0x00800000 (denormal vs min normal) -> shift_amt=0, sig_small=0x000001, sig_big=0x800000.
//   0x7F800000 - 0x7F800000 -> is_nan=1, is_inf=0; 0x7F800000 + 0x3F800000 -> is_inf=1, sign_res=0.
//   Back-pressure: stream 8 pairs, out_ready low cycles 3-6 -> in_ready low once both stages full; all 8 results in order, none lost.
//   Assert rst with both stages valid -> next cycle out_valid=0, all outputs 0, in_ready=1.

Source files
------------

// File: rtl/fpu_add_exp_compare.sv
// FP32 add/sub front end: unpacks both operands, orders them by magnitude and derives the
// clamped alignment shift, effective operation and special-case flags over two pipeline stages.
`timescale 1ns/1ps
module fpu_add_exp_compare #(
   parameter int EXP_W     = 8,
   parameter int SIG_W     = 24,
   parameter int SHIFT_CAP = 27
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      op_a,
   input  logic [31:0]      op_b,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SIG_W-1:0] sig_big,
   output logic [SIG_W-1:0] sig_small,
   output logic [4:0]       shift_amt,
   output logic [EXP_W-1:0] exp_big,
   output logic             sign_res,
   output logic             eff_sub,
   output logic             is_nan,
   output logic             is_inf,
   output logic             is_zero
);
   localparam int FRAC_W = SIG_W - 1;
   localparam int SIGN_B = EXP_W + FRAC_W;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [SIG_W-1:0] sig;
      logic             nan;
      logic             inf;
      logic             zero;
   } unpacked_t;

   // Denormals take effective exponent 1 with a clear hidden bit so they align like min normals.
   function automatic unpacked_t unpack(input logic [31:0] op, input logic flip);
      unpacked_t         u;
      logic [EXP_W-1:0]  e_raw;
      logic [FRAC_W-1:0] frac;
      e_raw  = op[FRAC_W +: EXP_W];
      frac   = op[FRAC_W-1:0];
      u.sign = op[SIGN_B] ^ flip;
      u.exp  = (e_raw == '0) ? EXP_W'(1) : e_raw;
      u.sig  = {(e_raw != '0), frac};
      u.nan  = (e_raw == '1) && (frac != '0);
      u.inf  = (e_raw == '1) && (frac == '0);
      u.zero = (e_raw == '0) && (frac == '0);
      return u;
   endfunction

   function automatic logic [4:0] sat_shift(input logic [EXP_W-1:0] diff);
      if (diff > EXP_W'(SHIFT_CAP))
         return 5'(SHIFT_CAP);
      else
         return diff[4:0];
   endfunction

   logic      vld_p1;
   logic      vld_p2;
   logic      s1_adv;
   logic      s2_adv;
   unpacked_t opa_p1;
   unpacked_t opb_p1;

   assign s2_adv   = !vld_p2 || out_ready;
   assign s1_adv   = !vld_p1 || s2_adv;
   assign in_ready = s1_adv;

   // ---- Stage 1: unpack and classify on input accept
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         opa_p1 <= '0;
         opb_p1 <= '0;
      end else if (s1_adv) begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            opa_p1 <= unpack(op_a, 1'b0);
            opb_p1 <= unpack(op_b, op_sub);
         end
      end
   end

   logic             a_big_c;
   logic [EXP_W-1:0] exp_big_c;
   logic [EXP_W-1:0] exp_small_c;
   logic [SIG_W-1:0] sig_big_c;
   logic [SIG_W-1:0] sig_small_c;
   logic             eff_sub_c;
   logic             nan_c;
   logic             inf_c;
   logic             zero_c;
   logic             sign_c;

   always_comb begin
      a_big_c     = {opa_p1.exp, opa_p1.sig} >= {opb_p1.exp, opb_p1.sig};
      exp_big_c   = a_big_c ? opa_p1.exp : opb_p1.exp;
      exp_small_c = a_big_c ? opb_p1.exp : opa_p1.exp;
      sig_big_c   = a_big_c ? opa_p1.sig : opb_p1.sig;
      sig_small_c = a_big_c ? opb_p1.sig : opa_p1.sig;
      eff_sub_c   = opa_p1.sign ^ opb_p1.sign;
      nan_c       = opa_p1.nan || opb_p1.nan || (opa_p1.inf && opb_p1.inf && eff_sub_c);
      inf_c       = !nan_c && (opa_p1.inf || opb_p1.inf);
      zero_c      = opa_p1.zero && opb_p1.zero;
      // An infinity always wins the magnitude compare, so the big sign is already the inf sign.
      sign_c      = zero_c ? (opa_p1.sign & opb_p1.sign)
                           : (a_big_c ? opa_p1.sign : opb_p1.sign);
   end

   logic [SIG_W-1:0] sig_big_p2;
   logic [SIG_W-1:0] sig_small_p2;
   logic [4:0]       shift_amt_p2;
   logic [EXP_W-1:0] exp_big_p2;
   logic             sign_p2;
   logic             eff_sub_p2;
   logic             nan_p2;
   logic             inf_p2;
   logic             zero_p2;

   // ---- Stage 2: magnitude swap, saturated shift and specials on S1->S2 advance
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2       <= 1'b0;
         sig_big_p2   <= '0;
         sig_small_p2 <= '0;
         shift_amt_p2 <= '0;
         exp_big_p2   <= '0;
         sign_p2      <= 1'b0;
         eff_sub_p2   <= 1'b0;
         nan_p2       <= 1'b0;
         inf_p2       <= 1'b0;
         zero_p2      <= 1'b0;
      end else if (s2_adv) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            sig_big_p2   <= sig_big_c;
            sig_small_p2 <= sig_small_c;
            shift_amt_p2 <= sat_shift(exp_big_c - exp_small_c);
            exp_big_p2   <= exp_big_c;
            sign_p2      <= sign_c;
            eff_sub_p2   <= eff_sub_c;
            nan_p2       <= nan_c;
            inf_p2       <= inf_c;
            zero_p2      <= zero_c;
         end
      end
   end

   assign out_valid = vld_p2;
   assign sig_big   = sig_big_p2;
   assign sig_small = sig_small_p2;
   assign shift_amt = shift_amt_p2;
   assign exp_big   = exp_big_p2;
   assign sign_res  = sign_p2;
   assign eff_sub   = eff_sub_p2;
   assign is_nan    = nan_p2;
   assign is_inf    = inf_p2;
   assign is_zero   = zero_p2;

endmodule
